// File: rtl/sparc_wide_decoder_pkg.sv
// Shared types and opcode constants for the SPARC V8 wide decode stage:
// micro-op layout, operand descriptors and the decode-side stall FSM states.
package sparc_wide_decoder_pkg;

    typedef enum logic [1:0] {
        DC_NORM,
        DC_DELAYED,
        DC_STALL
    } dc_state_t;

    typedef enum logic [2:0] {
        OPRD_T_NONE,
        OPRD_T_RD,
        OPRD_T_RS,
        OPRD_T_IMM,
        OPRD_T_DISP
    } oprd_kind_t;

    typedef struct packed {
        oprd_kind_t  kind;
        logic [31:0] val;
    } oprd_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic [8:0]  opf;
        logic [3:0]  cond;
        logic        annul_flag;
        oprd_t       oprd1;
        oprd_t       oprd2;
        oprd_t       oprd3;
        logic [63:0] next_rip;
    } micro_op_t;

    localparam logic [1:0] OP_FMT2 = 2'd0;
    localparam logic [1:0] OP_CALL = 2'd1;
    localparam logic [1:0] OP_FMT3 = 2'd2;
    localparam logic [1:0] OP_MEM  = 2'd3;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;
    localparam logic [2:0] OP2_FBFCC = 3'b110;
    localparam logic [2:0] OP2_CBCCC = 3'b111;

    localparam logic [5:0] OP3_FPOP1   = 6'h34;
    localparam logic [5:0] OP3_FPOP2   = 6'h35;
    localparam logic [5:0] OP3_JMPL    = 6'h38;
    localparam logic [5:0] OP3_RETT    = 6'h39;
    localparam logic [5:0] OP3_TICC    = 6'h3A;
    localparam logic [5:0] OP3_SAVE    = 6'h3C;
    localparam logic [5:0] OP3_RESTORE = 6'h3D;

    localparam logic [4:0] REG_G0 = 5'd0;
    localparam logic [4:0] REG_O0 = 5'd8;

    localparam logic [3:0]  COND_ALWAYS  = 4'h8;
    localparam logic [12:0] TRAP_SYSCALL = 13'h010;

    function automatic oprd_t mk_oprd(input oprd_kind_t kind, input logic [31:0] val);
        oprd_t o;
        o.kind = kind;
        o.val  = val;
        return o;
    endfunction

    function automatic oprd_t reg_oprd(input oprd_kind_t kind, input logic [4:0] r);
        return mk_oprd(kind, {27'd0, r});
    endfunction

endpackage

// File: rtl/sparc_insn_crack.sv
// Single-word SPARC V8 cracker: raw 32-bit instruction to micro_op_t plus the
// control-flow classification flags the top-level scan needs.
module sparc_insn_crack
    import sparc_wide_decoder_pkg::*;
(
    input  logic [31:0] insn,
    input  logic [63:0] pc_next,
    output micro_op_t   uop,
    output logic        is_dcti,
    output logic        is_stall,
    output logic        is_restore
);

    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        imm_sel;
    logic [31:0] simm13;
    oprd_t       src2;

    assign op      = insn[31:30];
    assign op2     = insn[24:22];
    assign op3     = insn[24:19];
    assign rd      = insn[29:25];
    assign rs1     = insn[18:14];
    assign rs2     = insn[4:0];
    assign imm_sel = insn[13];
    assign simm13  = {{19{insn[12]}}, insn[12:0]};
    assign src2    = imm_sel ? mk_oprd(OPRD_T_IMM, simm13) : reg_oprd(OPRD_T_RS, rs2);

    always_comb begin
        uop            = '0;
        uop.op         = op;
        uop.op2        = op2;
        uop.op3        = op3;
        uop.cond       = insn[28:25];
        uop.annul_flag = insn[29];
        uop.next_rip   = pc_next;
        case (op)
            OP_FMT2: begin
                if (op2 == OP2_SETHI) begin
                    uop.oprd1 = reg_oprd(OPRD_T_RD, rd);
                    uop.oprd2 = mk_oprd(OPRD_T_IMM, {insn[21:0], 10'd0});
                end else if (op2 == OP2_BICC || op2 == OP2_FBFCC || op2 == OP2_CBCCC) begin
                    uop.oprd1 = mk_oprd(OPRD_T_DISP, {{8{insn[21]}}, insn[21:0], 2'b00});
                end
            end
            OP_CALL: begin
                uop.oprd1 = mk_oprd(OPRD_T_DISP, {insn[29:0], 2'b00});
            end
            OP_FMT3: begin
                if (op3 == OP3_FPOP1 || op3 == OP3_FPOP2) begin
                    uop.opf = insn[13:5];
                end
                // Only the "ta 0x10" system-call trap names an implicit source (%o0).
                if (op3 == OP3_TICC) begin
                    if (insn[28:25] == COND_ALWAYS && imm_sel && rs1 == REG_G0
                        && insn[12:0] == TRAP_SYSCALL) begin
                        uop.oprd1 = reg_oprd(OPRD_T_RS, REG_O0);
                    end
                end else begin
                    uop.oprd1 = reg_oprd(OPRD_T_RD, rd);
                end
                uop.oprd2 = reg_oprd(OPRD_T_RS, rs1);
                uop.oprd3 = src2;
            end
            default: begin
                // Stores (op3 low nibble 4..7) read rd; everything else writes it.
                uop.oprd1 = (op3[3:2] == 2'b01) ? reg_oprd(OPRD_T_RS, rd) : reg_oprd(OPRD_T_RD, rd);
                uop.oprd2 = reg_oprd(OPRD_T_RS, rs1);
                uop.oprd3 = src2;
            end
        endcase
    end

    assign is_dcti = (op == OP_FMT2 && (op2 == OP2_BICC || op2 == OP2_FBFCC || op2 == OP2_CBCCC))
                  || (op == OP_CALL)
                  || (op == OP_FMT3 && op3 == OP3_JMPL);

    assign is_stall = (op == OP_FMT3) && (op3 == OP3_RETT || op3 == OP3_TICC
                                          || op3 == OP3_SAVE || op3 == OP3_RESTORE);

    assign is_restore = (op == OP_FMT3) && (op3 == OP3_RESTORE);

endmodule

// File: rtl/sparc_wide_decoder.sv
// Multi-issue SPARC V8 decode stage: cracks up to DC_WIDTH words per cycle,
// tracks delay-slot/trap stalls and buffers uops in a circular queue toward dispatch.
module sparc_wide_decoder
    import sparc_wide_decoder_pkg::*;
#(
    parameter int DC_WIDTH    = 4,
    parameter int BUF_DEPTH   = 16,
    parameter int FETCH_BYTES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       can_decode,
    input  logic [63:0]                rip,
    input  logic [FETCH_BYTES*8-1:0]   decode_bytes,
    output logic [7:0]                 bytes_decoded,
    input  logic                       dc_resume,
    input  logic                       dc_flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output micro_op_t                  out_uop,
    output logic [$clog2(BUF_DEPTH):0] buf_count
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(DC_WIDTH + 1);

    micro_op_t             crack_uop [DC_WIDTH];
    micro_op_t             wr_uop    [DC_WIDTH];
    logic [DC_WIDTH-1:0]   dcti;
    logic [DC_WIDTH-1:0]   stall;
    logic [DC_WIDTH-1:0]   restore;

    micro_op_t             mem [BUF_DEPTH];
    logic [PW-1:0]         head_reg;
    logic [PW-1:0]         tail_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         free_slots;

    dc_state_t             state_reg;
    dc_state_t             state_next;
    dc_state_t             scan_state;
    logic                  scan_done;
    logic                  decode_en;
    logic                  pop;
    logic [KW-1:0]         k;

    genvar gi;
    generate
        for (gi = 0; gi < DC_WIDTH; gi++) begin : g_crack
            sparc_insn_crack u_crack (
                .insn       (decode_bytes[gi*32 +: 32]),
                .pc_next    (rip + 64'(4 * (gi + 1))),
                .uop        (crack_uop[gi]),
                .is_dcti    (dcti[gi]),
                .is_stall   (stall[gi]),
                .is_restore (restore[gi])
            );
        end
    endgenerate

    assign free_slots = CW'(BUF_DEPTH) - count_reg;
    assign decode_en  = can_decode && !reset && !dc_flush && (state_reg != DC_STALL);

    // Walk the window in order, carrying the FSM state word by word to find k.
    always_comb begin
        scan_state = state_reg;
        scan_done  = !decode_en;
        k          = '0;
        for (int i = 0; i < DC_WIDTH; i++) begin
            wr_uop[i] = crack_uop[i];
            if (!scan_done && i < int'(free_slots)) begin
                k = KW'(i + 1);
                if (scan_state == DC_DELAYED) begin
                    if (restore[i]) begin
                        wr_uop[i].next_rip = '0;
                    end
                    scan_state = DC_STALL;
                    scan_done  = 1'b1;
                end else if (stall[i]) begin
                    scan_state = DC_STALL;
                    scan_done  = 1'b1;
                end else if (dcti[i]) begin
                    scan_state = DC_DELAYED;
                end
            end
        end
    end

    assign bytes_decoded = 8'({k, 2'b00});

    always_comb begin
        state_next = state_reg;
        if (dc_flush) begin
            state_next = DC_NORM;
        end else if (state_reg == DC_STALL) begin
            if (dc_resume) begin
                state_next = DC_NORM;
            end
        end else if (decode_en) begin
            state_next = scan_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DC_NORM;
        end else begin
            state_reg <= state_next;
        end
    end

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign out_uop   = out_valid ? mem[tail_reg] : '0;
    assign buf_count = count_reg;

    // Pointers are exactly PW bits wide, so wrap-around is implicit in the addition.
    always_ff @(posedge clk) begin
        if (reset || dc_flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PW'(k);
            tail_reg  <= tail_reg + PW'(pop);
            count_reg <= count_reg + CW'(k) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DC_WIDTH; i++) begin
            if (KW'(i) < k) begin
                mem[head_reg + PW'(i)] <= wr_uop[i];
            end
        end
    end

    a_resume_only_in_stall: assert property (@(posedge clk) disable iff (reset)
        dc_resume |-> (state_reg == DC_STALL));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (int'(count_reg) + int'(k)) <= BUF_DEPTH);

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset)
        pop |-> (count_reg != '0));

endmodule

// File: tb/tb_sparc_wide_decoder.sv
// Scoreboard bench for sparc_wide_decoder: an instruction-level reference model
// predicts each cycle's uops; a monitor checks the queue head as it drains.
module tb_sparc_wide_decoder;
    import sparc_wide_decoder_pkg::*;

    localparam int DCW   = 4;
    localparam int DEPTH = 16;
    localparam int FB    = 16;

    localparam logic [31:0] W_ADD     = 32'h84006005;
    localparam logic [31:0] W_BA      = 32'h10800002;
    localparam logic [31:0] W_NOP     = 32'h01000000;
    localparam logic [31:0] W_RESTORE = 32'h81e80000;
    localparam logic [31:0] W_TA      = 32'h91d02010;
    localparam logic [31:0] W_CALL    = 32'h40000004;
    localparam logic [31:0] W_RETL    = 32'h81c3e008;
    localparam logic [31:0] W_SAVE    = 32'h9de3bfa0;
    localparam logic [31:0] W_LD      = 32'hc4006004;
    localparam logic [31:0] W_ST      = 32'hc4206004;
    localparam logic [31:0] W_FBA     = 32'h11800003;
    localparam logic [31:0] W_FMOV    = 32'h81a00020;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   can_decode = 1'b0;
    logic [63:0]            rip = '0;
    logic [FB*8-1:0]        decode_bytes = '0;
    logic [7:0]             bytes_decoded;
    logic                   dc_resume = 1'b0;
    logic                   dc_flush = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    micro_op_t              out_uop;
    logic [4:0]             buf_count;

    always #5 clk = ~clk;

    sparc_wide_decoder #(.DC_WIDTH(DCW), .BUF_DEPTH(DEPTH), .FETCH_BYTES(FB)) dut (
        .clk           (clk),
        .reset         (reset),
        .can_decode    (can_decode),
        .rip           (rip),
        .decode_bytes  (decode_bytes),
        .bytes_decoded (bytes_decoded),
        .dc_resume     (dc_resume),
        .dc_flush      (dc_flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_uop       (out_uop),
        .buf_count     (buf_count)
    );

    int        vectors = 0;
    int        errors = 0;
    micro_op_t exp_q[$];
    micro_op_t stage_q[$];
    bit        clear_pend = 1'b0;
    bit        m_stalled = 1'b0;
    bit        m_pending = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit ref_is_cti(input logic [31:0] w);
        return (w[31:30] == 2'd0 && (w[24:22] == 3'd2 || w[24:22] == 3'd6 || w[24:22] == 3'd7))
            || (w[31:30] == 2'd1)
            || (w[31:30] == 2'd2 && w[24:19] == 6'h38);
    endfunction

    function automatic bit ref_is_stall(input logic [31:0] w);
        return w[31:30] == 2'd2 && (w[24:19] == 6'h39 || w[24:19] == 6'h3A
                                    || w[24:19] == 6'h3C || w[24:19] == 6'h3D);
    endfunction

    // Instruction semantics from the SPARC V8 field definitions, using integer arithmetic.
    function automatic micro_op_t ref_crack(input logic [31:0] w, input logic [63:0] nrip);
        micro_op_t u;
        int        simm;
        int        disp;
        oprd_t     second;
        u = '0;
        u.op = w[31:30];
        u.annul_flag = w[29];
        u.cond = w[28:25];
        u.op2 = w[24:22];
        u.op3 = w[24:19];
        u.next_rip = nrip;
        simm = int'(w[12:0]);
        if (w[12]) simm -= 8192;
        if (w[13]) second = '{kind: OPRD_T_IMM, val: 32'(simm)};
        else       second = '{kind: OPRD_T_RS, val: 32'(w[4:0])};
        case (w[31:30])
            2'd0: begin
                if (w[24:22] == 3'd4) begin
                    u.oprd1 = '{kind: OPRD_T_RD, val: 32'(w[29:25])};
                    u.oprd2 = '{kind: OPRD_T_IMM, val: 32'(longint'(w[21:0]) * 1024)};
                end else if (w[24:22] == 3'd2 || w[24:22] == 3'd6 || w[24:22] == 3'd7) begin
                    disp = int'(w[21:0]);
                    if (w[21]) disp -= (1 << 22);
                    u.oprd1 = '{kind: OPRD_T_DISP, val: 32'(disp * 4)};
                end
            end
            2'd1: u.oprd1 = '{kind: OPRD_T_DISP, val: 32'(longint'(w[29:0]) * 4)};
            2'd2: begin
                if (w[24:19] == 6'h34 || w[24:19] == 6'h35) u.opf = w[13:5];
                if (w[24:19] == 6'h3A) begin
                    if (w[28:25] == 4'd8 && w[13] && w[18:14] == 5'd0 && simm == 16)
                        u.oprd1 = '{kind: OPRD_T_RS, val: 32'd8};
                end else begin
                    u.oprd1 = '{kind: OPRD_T_RD, val: 32'(w[29:25])};
                end
                u.oprd2 = '{kind: OPRD_T_RS, val: 32'(w[18:14])};
                u.oprd3 = second;
            end
            default: begin
                if (w[22:19] >= 4 && w[22:19] <= 7) u.oprd1 = '{kind: OPRD_T_RS, val: 32'(w[29:25])};
                else                                u.oprd1 = '{kind: OPRD_T_RD, val: 32'(w[29:25])};
                u.oprd2 = '{kind: OPRD_T_RS, val: 32'(w[18:14])};
                u.oprd3 = second;
            end
        endcase
        return u;
    endfunction

    function automatic logic [31:0] pick_word();
        int sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:  return W_BA;
            1:  return W_NOP;
            2:  return W_RESTORE;
            3:  return W_TA;
            4:  return W_CALL;
            5:  return W_RETL;
            6:  return W_SAVE;
            7:  return W_LD;
            8:  return W_ST;
            9:  return W_FBA;
            10: return W_FMOV;
            11, 12: return $urandom();
            default: return W_ADD;
        endcase
    endfunction

    // One bus cycle: drive inputs, check comb/occupancy outputs, stage predicted uops.
    task automatic cycle(input bit rst, input bit can, input logic [31:0] w[4],
                         input bit resume, input bit flush, input bit ready, input int want_k);
        int        n;
        int        room;
        micro_op_t u;
        @(posedge clk);
        #1;
        reset = rst;
        can_decode = can;
        dc_resume = resume;
        dc_flush = flush;
        out_ready = ready;
        rip = {$urandom(), $urandom()};
        rip[1:0] = 2'b00;
        for (int i = 0; i < 4; i++) decode_bytes[i*32 +: 32] = w[i];
        #1;
        check("buf_count", buf_count, exp_q.size());
        n = 0;
        if (rst || flush) begin
            clear_pend = 1'b1;
            m_stalled = 1'b0;
            m_pending = 1'b0;
        end else if (m_stalled) begin
            if (resume) m_stalled = 1'b0;
        end else if (can) begin
            room = DEPTH - exp_q.size();
            if (room > DCW) room = DCW;
            for (int i = 0; i < room; i++) begin
                u = ref_crack(w[i], rip + 64'(4 * (i + 1)));
                n++;
                if (m_pending) begin
                    if (w[i] == W_RESTORE || (w[i][31:30] == 2'd2 && w[i][24:19] == 6'h3D))
                        u.next_rip = '0;
                    stage_q.push_back(u);
                    m_pending = 1'b0;
                    m_stalled = 1'b1;
                    break;
                end
                stage_q.push_back(u);
                if (ref_is_stall(w[i])) begin
                    m_stalled = 1'b1;
                    break;
                end
                if (ref_is_cti(w[i])) m_pending = 1'b1;
            end
        end
        check("bytes_decoded", bytes_decoded, 4 * n);
        if (want_k >= 0) check("k_directed", bytes_decoded, 4 * want_k);
        $display("cycle rst=%0b can=%0b res=%0b fl=%0b rdy=%0b k=%0d count=%0d", rst, can, resume, flush, ready, n, buf_count);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check("out_valid", out_valid, 1);
                check("out_uop", out_uop, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("out_valid_empty", out_valid, 0);
            end
            if (clear_pend) begin
                exp_q.delete();
                clear_pend = 1'b0;
            end
            while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] ws[4];
    logic [31:0] zw[4];

    task automatic drain();
        for (int t = 0; t < 40 && (exp_q.size() + stage_q.size()) > 0; t++)
            cycle(1'b0, 1'b0, zw, 1'b0, 1'b0, 1'b1, -1);
        check("drain_timeout", exp_q.size() + stage_q.size(), 0);
    endtask

    initial begin
        zw = '{32'd0, 32'd0, 32'd0, 32'd0};
        ws = '{W_ADD, W_ADD, W_ADD, W_ADD};
        cycle(1'b1, 1'b1, ws, 1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, ws, 1'b0, 1'b0, 1'b0, 0);
        check("reset_out_uop", out_uop, 0);
        check("reset_buf_count", buf_count, 0);

        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 4);
        cycle(1'b0, 1'b0, zw, 1'b0, 1'b0, 1'b0, 0);
        check("t1_count", buf_count, 4);
        check("t1_imm_kind", out_uop.oprd3.kind, OPRD_T_IMM);
        check("t1_imm_val", out_uop.oprd3.val, 5);
        drain();

        ws = '{W_ADD, W_BA, W_NOP, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 3);
        ws = '{W_ADD, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b1, 4);
        drain();

        ws = '{W_ADD, W_ADD, W_ADD, W_BA};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 4);
        ws = '{W_RESTORE, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, 1'b1, ws, 1'b1, 1'b0, 1'b0, 0);
        drain();

        ws = '{W_ADD, W_ADD, W_ADD, W_ADD};
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 4);
        ws = '{W_ADD, W_RESTORE, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 2);
        cycle(1'b0, 1'b0, ws, 1'b1, 1'b0, 1'b0, 0);
        check("t4_count14", buf_count, 14);
        ws = '{W_ADD, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 0);
        check("t4_full", buf_count, 16);
        drain();

        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 4);
        ws = '{W_TA, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, 1'b1, ws, 1'b1, 1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, ws, 1'b0, 1'b0, 1'b0, 0);
        check("t6_flush_count", buf_count, 0);
        check("t6_flush_valid", out_valid, 0);
        ws = '{W_ADD, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 4);
        ws = '{W_TA, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, 1'b1, ws, 1'b0, 1'b0, 1'b1, 0);
        cycle(1'b0, 1'b0, ws, 1'b0, 1'b0, 1'b0, 0);
        check("t6_reset_count", buf_count, 0);
        check("t6_reset_valid", out_valid, 0);
        ws = '{W_ADD, W_ADD, W_ADD, W_ADD};
        cycle(1'b0, 1'b1, ws, 1'b0, 1'b0, 1'b1, 4);
        drain();

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) ws[i] = pick_word();
            cycle(1'b0, $urandom_range(0, 9) < 8, ws,
                  m_stalled && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 1) == 1, -1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
